// File: rtl/pwm_generator_if.sv
// Duty/run-control and waveform signals between the PIO side and the PWM block.
// Names follow the top-level wiring (pwm_input_0_export feeds duty_in).
interface pwm_generator_if;
    logic       enable;
    logic [7:0] duty_in;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;

    modport master (
        output enable,
        output duty_in,
        input  pwm_out,
        input  period_start,
        input  duty_active
    );

    modport slave (
        input  enable,
        input  duty_in,
        output pwm_out,
        output period_start,
        output duty_active
    );
endinterface

// File: rtl/pwm_generator.sv
// Fixed-frequency PWM with duty double-buffered at period boundaries.
// Define PWM_RAMP_EN to slew-limit duty changes by RAMP_STEP per period.
module pwm_generator #(
    parameter int unsigned PRESCALE  = 50,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    pwm_generator_if.slave bus
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        enable_q, enable_d;
    logic [7:0]  duty_q, duty_d;
    logic        pwm_q, pwm_d;
    logic        start_q, start_d;
    logic        tick;
    logic        boundary;
    logic        rise;
    logic [7:0]  duty_next;
    logic [7:0]  duty_idle;

    assign tick     = bus.enable && (pre_cnt_q == PRE_LAST);
    assign boundary = tick && (cnt_q == 8'hFF);
    assign rise     = bus.enable && !enable_q;

`ifdef PWM_RAMP_EN
    localparam logic [7:0] STEP8 = 8'(RAMP_STEP);

    logic [8:0] want9;
    logic [8:0] have9;
    logic [8:0] step9;

    assign want9 = {1'b0, bus.duty_in};
    assign have9 = {1'b0, duty_q};
    assign step9 = {1'b0, STEP8};

    // Move toward the request by at most one step; 9-bit math cannot wrap.
    always_comb begin
        duty_next = bus.duty_in;
        if (want9 > have9) begin
            if ((want9 - have9) > step9) begin
                duty_next = duty_q + STEP8;
            end
        end else if ((have9 - want9) > step9) begin
            duty_next = duty_q - STEP8;
        end
    end

    // Soft start: every enable begins from zero duty.
    assign duty_idle = 8'd0;
`else
    assign duty_next = bus.duty_in;
    assign duty_idle = bus.duty_in;
`endif

    // Next-state for prescaler, period counter, shadow duty and outputs.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        pwm_d     = 1'b0;
        start_d   = 1'b0;
        enable_d  = bus.enable;
        if (!bus.enable) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
            duty_d    = duty_idle;
        end else begin
            pwm_d   = (cnt_q < duty_q);
            start_d = rise;
            if (tick) begin
                pre_cnt_d = '0;
                if (boundary) begin
                    cnt_d   = '0;
                    duty_d  = duty_next;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                pre_cnt_d = pre_cnt_q + 16'd1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            start_q   <= start_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = start_q;
    assign bus.duty_active  = duty_q;
endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: per-period records are predicted by
// the stimulus and checked by a monitor that measures the waveform.
module tb_pwm_generator;
    localparam int P    = 3;
    localparam int STEP = 4;
    localparam int PER  = 256 * P;

    typedef struct {
        int da;
        int hi;
        int len;
    } rec_t;

    logic clk_clk = 1'b0;
    logic rst_n   = 1'b0;

    pwm_generator_if bus ();

    pwm_generator #(
        .PRESCALE  (P),
        .RAMP_STEP (STEP)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    always #5 clk_clk = ~clk_clk;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   da    = 0;

    int   hi_c    = 0;
    int   len_c   = 0;
    int   da_seen = 0;
    bit   open_w  = 1'b0;
    bit   prev_en = 1'b0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int ramp_to(int cur, int tgt);
`ifdef PWM_RAMP_EN
        if (tgt > cur) return (tgt - cur <= STEP) ? tgt : cur + STEP;
        return (cur - tgt <= STEP) ? tgt : cur - STEP;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    function automatic int idle_duty(int din);
`ifdef PWM_RAMP_EN
        return 0 * din;
`else
        return din;
`endif
    endfunction

    task automatic close_w();
        rec_t r;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got hi=%0d len=%0d want no period", hi_c, len_c);
        end else begin
            r = q.pop_front();
            chk("period_duty", da_seen, r.da);
            chk("period_high", hi_c, r.hi);
            chk("period_len", len_c, r.len);
        end
        open_w = 1'b0;
    endtask

    // Monitor: a window runs from one period_start to the next (or to enable low).
    always @(negedge clk_clk) begin
        if (rst_n) begin
            if (!prev_en) begin
                chk("off_pwm", int'(bus.pwm_out), 0);
                chk("off_start", int'(bus.period_start), 0);
            end
            if (bus.period_start) begin
                if (open_w) close_w();
                open_w  = 1'b1;
                hi_c    = 0;
                len_c   = 0;
                da_seen = int'(bus.duty_active);
            end
            if (open_w) begin
                hi_c  += int'(bus.pwm_out);
                len_c += 1;
            end
            if (!bus.enable && open_w) close_w();
            prev_en = bus.enable;
        end
    end

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic dis(int n, int dfin);
        for (int i = 0; i < n; i++) begin
            bus.duty_in = (i == n - 1) ? 8'(dfin) : 8'($urandom_range(255, 0));
            cyc();
            da = idle_duty(int'(bus.duty_in));
        end
    endtask

    // Enable for nper full periods, then drop enable at offset o of the next.
    task automatic run(int nper, int o, bit chg);
        rec_t r;
        bit   last;
        int   plen;
        int   c;
        int   nd;
        bus.enable = 1'b1;
        for (int m = 0; m <= nper; m++) begin
            last  = (m == nper);
            r.da  = da;
            if (last) begin
                r.hi  = (o < da * P) ? o : da * P;
                r.len = o + ((m > 0) ? 1 : 0);
                plen  = o;
            end else begin
                r.hi  = da * P;
                r.len = (m == 0) ? PER - 1 : PER;
                plen  = PER;
            end
            q.push_back(r);
            c  = (chg && $urandom_range(1, 0) == 1) ? int'($urandom_range(PER - 2, 0)) : -1;
            nd = int'($urandom_range(255, 0));
            for (int k = 0; k < plen; k++) begin
                if (k == c) bus.duty_in = 8'(nd);
                cyc();
            end
            if (!last) da = ramp_to(da, int'(bus.duty_in));
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        int n;
        int o;
        bus.enable  = 1'b1;
        bus.duty_in = 8'd128;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        chk("rst_pwm", int'(bus.pwm_out), 0);
        chk("rst_start", int'(bus.period_start), 0);
        chk("rst_duty", int'(bus.duty_active), 0);
        @(posedge clk_clk);
        #1;
        rst_n = 1'b1;
        da    = 0;
        run(2, 100, 1'b0);

        dis(10, 64);
        run(3, 30 * P, 1'b0);
        dis(10, 64);
        run(2, PER - 1, 1'b0);
        dis(8, 0);
        run(3, 5, 1'b0);
        dis(8, 255);
        run(3, 10, 1'b0);

        for (int i = 0; i < 8; i++) begin
            dis(int'($urandom_range(20, 3)), int'($urandom_range(255, 0)));
            n = int'($urandom_range(3, 0));
            o = (n == 0) ? int'($urandom_range(PER - 1, 1))
                         : int'($urandom_range(PER - 1, 0));
            run(n, o, 1'b1);
        end

        dis(5, 0);
        repeat (2) @(negedge clk_clk);
        chk("sb_drain", q.size(), 0);
        chk("win_open", int'(open_w), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Downstream consumer of the 8-bit `pwm_input_0_export` duty word that the HPS writes through the system PIO.
- Produces a glitch-free, fixed-frequency PWM waveform on one fabric pin.
- Duty updates are double-buffered and applied only at period boundaries.
- Sits in the top level between the system instance and the output pin, on `clk_clk`.

Parameters:
- PRESCALE, 50: `clk_clk` cycles per PWM counter tick. Legal range 1..65535.
- RAMP_STEP, 4: maximum duty change per period. Used only when PWM_RAMP_EN is defined. Legal range 1..255.

Ports:
- clk_clk  input  1  system clock
- reset_reset_n  input  1  asynchronous active-low reset
- enable  input  1  run control; low forces output off and restarts the period
- duty_in  input  8  requested duty, from `pwm_input_0_export`
- pwm_out  output  1  registered PWM waveform
- period_start  output  1  one-cycle pulse marking the start of each period
- duty_active  output  8  duty currently being generated (shadow register)

Behaviour:
- Reset (async assert, sync release): all of the following are 0:
  - registers pre_cnt, cnt, enable_q
  - outputs duty_active, pwm_out, period_start
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1.
  - tick = enable && (pre_cnt == PRESCALE-1).
  - On tick, pre_cnt wraps to 0.
  - PRESCALE=1 gives tick on every enabled cycle.
- Period counter:
  - cnt is 8 bits and increments on tick; it wraps 255 to 0.
  - Period = 256*PRESCALE clocks.
- Boundary event: tick && cnt == 255. On that edge:
  - cnt <= 0
  - duty_active <= duty_in (ramped value if PWM_RAMP_EN)
  - period_start <= 1
- duty_in changes mid-period have no effect until the next boundary. There is no partial period and no glitch.
- Output:
  - pwm_out(t+1) = enable(t) && (cnt(t) < duty_active(t)).
  - This gives one clock of latency from cnt.
  - High time per period = duty_active*PRESCALE clocks exactly.
  - duty 0: constant low.
  - duty 255: low for PRESCALE clocks per period.
- enable low:
  - pre_cnt and cnt are cleared to 0 and held.
  - pwm_out is 0 from the next edge.
  - duty_active <= duty_in every cycle (no-ramp build).
- enable rising (enable=1, enable_q=0):
  - period_start <= 1.
  - cnt starts at 0 with the duty_active already loaded.
  - First high cycle on pwm_out appears on the following edge.
- period_start:
  - 1 for exactly one cycle after a boundary or an enable rise, else 0.
  - Never asserted while enable is low.
- Simultaneous boundary and enable fall: enable wins. cnt=0, pwm_out=0, no period_start.
- Reset mid-period: immediate return to reset values. Restart obeys the enable-rising rules.

Optional Feature:
- Macro: PWM_RAMP_EN
- Defined (soft-start/slew limit):
  - At each boundary, duty_active moves toward duty_in by at most RAMP_STEP.
  - If |duty_in - duty_active| <= RAMP_STEP, duty_active <= duty_in.
  - Arithmetic uses 9-bit compare; results never wrap below 0 or above 255.
  - While enable is low, duty_active is held at 0, so every enable starts from 0 and ramps up.
  - Rate of decrease equals rate of increase.
- Undefined:
  - duty_active loads duty_in directly at boundaries and while disabled.
  - RAMP_STEP is ignored.
  - No extra registers.

Test Plan:
- Reset check: hold reset_reset_n=0 with enable=1, duty_in=128 -> pwm_out=0, period_start=0, duty_active=0. Release -> first period_start one cycle after the first enabled edge.
- Steady duty: PRESCALE=1, duty_in=64, enable=1 -> pwm_out high 64 clocks and low 192 per period. period_start every 256 clocks, aligned one cycle before the first high cycle.
- Extremes: duty_in=0 -> pwm_out never high over 3 periods. duty_in=255 -> exactly 1 low clock per 256.
- Mid-period update: duty 64, change duty_in to 192 when cnt=100 -> current period still 64 high. Next period 192 high, duty_active=192 from the boundary.
- Enable abort/restart:
  - Drop enable while pwm_out is high at cnt=30 -> pwm_out=0 next edge, cnt=0.
  - Re-enable after 10 clocks -> single period_start pulse and a full 64-high period.
- Prescale and ramp:
  - PRESCALE=4, duty 10 -> 40 high clocks per 1024.
  - With PWM_RAMP_EN, RAMP_STEP=4, enable with duty_in=18 -> duty_active 4, 8, 12, 16, 18 on successive boundaries.
  - Then duty_in=0 -> 14, 10, 6, 2, 0.
